// File: rtl/sched_pkg.sv
// Shared types and index helpers for the issue-port scheduler.
package sched_pkg;
   localparam int SCHED_WIDTH = 16;
   localparam int SCHED_REQS  = 5;
   localparam int SCHED_IDX_W = $clog2(SCHED_WIDTH);

   typedef logic [SCHED_IDX_W-1:0] idx_t;
   typedef logic [SCHED_WIDTH-1:0] mask_t;

   function automatic idx_t oh2idx(input mask_t oh);
      idx_t idx;
      idx = '0;
      for (int i = 0; i < SCHED_WIDTH; i++) begin
         if (oh[i]) idx = idx | idx_t'(i);
      end
      return idx;
   endfunction

   function automatic mask_t idx2oh(input idx_t idx);
      return mask_t'(1) << idx;
   endfunction
endpackage

// File: rtl/msb_psel_gen.sv
// Multi-grant selector: gnt_bus[j] is the j-th highest set request bit (one-hot).
module msb_psel_gen #(
   parameter int WIDTH = 16,
   parameter int REQS  = 5
) (
   input  logic [WIDTH-1:0]           req,
   output logic [REQS-1:0][WIDTH-1:0] gnt_bus,
   output logic [WIDTH-1:0]           gnt,
   output logic                       empty
);
   logic [WIDTH-1:0] remain;
   logic [WIDTH-1:0] pick;

   always_comb begin
      remain  = req;
      gnt_bus = '0;
      gnt     = '0;
      pick    = '0;
      for (int j = 0; j < REQS; j++) begin
         pick = '0;
         // Ascending scan: the last set bit seen is the highest one.
         for (int i = 0; i < WIDTH; i++) begin
            if (remain[i]) begin
               pick    = '0;
               pick[i] = 1'b1;
            end
         end
         gnt_bus[j] = pick;
         gnt        = gnt | pick;
         remain     = remain & ~pick;
      end
   end

   assign empty = ~|req;
endmodule

// File: rtl/issue_port_sched.sv
// Pending-request pool feeding REQS registered issue ports, highest index first.
module issue_port_sched
   import sched_pkg::*;
#(
   parameter int WIDTH = SCHED_WIDTH,
   parameter int REQS  = SCHED_REQS,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [WIDTH-1:0]           set_valid,
   input  logic                       flush,
   input  logic [REQS-1:0]            port_ready,
   output logic [REQS-1:0]            port_valid,
   output logic [REQS-1:0][IDX_W-1:0] port_idx,
   output logic [WIDTH-1:0]           pending,
   output logic                       empty
);
   localparam int SLOT_W = $clog2(REQS + 1);

   logic [WIDTH-1:0]           pending_q;
   logic [WIDTH-1:0]           held;
   logic [WIDTH-1:0]           clr;
   logic [WIDTH-1:0]           eligible;
   logic [REQS-1:0][WIDTH-1:0] gnt_bus;
   logic [WIDTH-1:0]           gnt_unused;
   logic                       empty_unused;
   logic [REQS-1:0]            valid_nxt;
   logic [REQS-1:0][IDX_W-1:0] idx_nxt;
   logic [SLOT_W-1:0]          slot;

   // An accepted entry is still held this cycle, so it cannot be re-granted now.
   always_comb begin
      held = '0;
      clr  = '0;
      for (int k = 0; k < REQS; k++) begin
         if (port_valid[k]) begin
            held = held | idx2oh(port_idx[k]);
            if (port_ready[k]) clr = clr | idx2oh(port_idx[k]);
         end
      end
   end

   assign eligible = pending_q & ~held;

   msb_psel_gen #(.WIDTH(WIDTH), .REQS(REQS)) u_psel (
      .req     (eligible),
      .gnt_bus (gnt_bus),
      .gnt     (gnt_unused),
      .empty   (empty_unused)
   );

   // Grant j lands on the j-th free port; surplus grants stay waiting.
   always_comb begin
      slot      = '0;
      valid_nxt = port_valid;
      idx_nxt   = port_idx;
      for (int k = 0; k < REQS; k++) begin
         if (~port_valid[k] | port_ready[k]) begin
            valid_nxt[k] = |gnt_bus[slot];
            if (|gnt_bus[slot]) idx_nxt[k] = oh2idx(gnt_bus[slot]);
            slot = slot + SLOT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending_q  <= '0;
         port_valid <= '0;
         port_idx   <= '0;
      end else if (flush) begin
         pending_q  <= '0;
         port_valid <= '0;
      end else begin
         pending_q  <= (pending_q & ~clr) | set_valid;
         port_valid <= valid_nxt;
         port_idx   <= idx_nxt;
      end
   end

   assign pending = pending_q;
   assign empty   = ~|pending_q & ~|port_valid;
endmodule
